// File: rtl/median_filter_stream.sv
// Streaming sliding-window median over the last WIN unsigned samples.
// Define MEDIAN_FILTER_MINMAX_EN to also register and expose the window min/max.
module median_filter_stream #(
    parameter int WIDTH = 8,
    parameter int WIN   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef MEDIAN_FILTER_MINMAX_EN
    output logic [WIDTH-1:0]         out_min,
    output logic [WIDTH-1:0]         out_max,
`endif
    output logic [$clog2(WIN+1)-1:0] fill_cnt
);
    localparam int CW = $clog2(WIN + 1);
    localparam int MID = (WIN - 1) / 2;
    localparam logic [CW-1:0] FULL = CW'(WIN);
    localparam logic [CW-1:0] LAST = CW'(WIN - 1);

    if ((WIN % 2) == 0 || WIN < 3 || WIN > 15 || WIDTH < 2 || WIDTH > 16) begin : g_cfg_err
        $error("median_filter_stream: WIN must be odd in 3..15 and WIDTH in 2..16");
    end

    typedef enum logic {FILL, RUN} state_t;
    state_t state;

    // age[WIN-1] is the oldest sample; sorted is non-decreasing over its valid entries
    logic [WIN-1:0][WIDTH-1:0] age, sorted, comp, base, nxt;
    int del_idx, ins_pos, n_valid;
    logic accept, emits;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emits    = (state == RUN) || (fill_cnt == LAST);

    // lowest-index copy of the outgoing sample
    always_comb begin
        del_idx = WIN - 1;
        for (int i = WIN - 1; i >= 0; i--)
            if (sorted[i] == age[WIN-1]) del_idx = i;
    end

    for (genvar g = 0; g < WIN; g++) begin : g_comp
        if (g < WIN - 1) begin : g_mid
            assign comp[g] = (g < del_idx) ? sorted[g] : sorted[g+1];
        end else begin : g_top
            assign comp[g] = '0;
        end
    end

    assign base    = (state == RUN) ? comp : sorted;
    assign n_valid = (state == RUN) ? WIN - 1 : int'(fill_cnt);

    // insertion point: after every valid entry <= in_data, so equals keep arrival order
    always_comb begin
        ins_pos = 0;
        for (int i = 0; i < WIN; i++)
            if (i < n_valid && base[i] <= in_data) ins_pos = ins_pos + 1;
    end

    for (genvar g = 0; g < WIN; g++) begin : g_ins
        if (g == 0) begin : g_first
            assign nxt[g] = (ins_pos == 0) ? in_data : base[0];
        end else begin : g_rest
            assign nxt[g] = (g < ins_pos) ? base[g] : (g == ins_pos) ? in_data : base[g-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            age       <= '0;
            sorted    <= '0;
`ifdef MEDIAN_FILTER_MINMAX_EN
            out_min   <= '0;
            out_max   <= '0;
`endif
        end else if (clear) begin
            state     <= FILL;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            age       <= '0;
            sorted    <= '0;
        end else if (accept) begin
            age    <= {age[WIN-2:0], in_data};
            sorted <= nxt;
            if (emits) begin
                state     <= RUN;
                fill_cnt  <= FULL;
                out_valid <= 1'b1;
                out_data  <= nxt[MID];
`ifdef MEDIAN_FILTER_MINMAX_EN
                out_min   <= nxt[0];
                out_max   <= nxt[WIN-1];
`endif
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_median_filter_stream.sv
// Scoreboarded random/directed bench for median_filter_stream (WIN=5/WIDTH=8 plus a WIN=3/WIDTH=4 instance).
module tb_median_filter_stream;
    localparam int WIDTH = 8;
    localparam int WIN   = 5;
    localparam int CW    = $clog2(WIN + 1);

    logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0] fill_cnt;
`ifdef MEDIAN_FILTER_MINMAX_EN
    logic [WIDTH-1:0] out_min, out_max;
`endif

    logic in3_valid = 1'b0, out3_ready = 1'b1, in3_ready, out3_valid;
    logic [3:0] in3_data = '0, out3_data;
    logic [1:0] fill3_cnt;

    always #5 clk = ~clk;

    median_filter_stream #(.WIDTH(WIDTH), .WIN(WIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MEDIAN_FILTER_MINMAX_EN
        .out_min(out_min), .out_max(out_max),
`endif
        .fill_cnt(fill_cnt)
    );

    median_filter_stream #(.WIDTH(4), .WIN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
        .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data),
`ifdef MEDIAN_FILTER_MINMAX_EN
        .out_min(), .out_max(),
`endif
        .fill_cnt(fill3_cnt)
    );

    typedef struct { int med; int mn; int mx; } exp_t;
    exp_t exp_q[$];
    int   win_q[$];
    int   checks = 0, errors = 0, last_med = 0;
    logic rand_ready = 1'b0, ready_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference: keep the last WIN accepted samples, median/min/max by sorting a copy
    task automatic model_push(input int v);
        int s[$];
        exp_t e;
        win_q.push_back(v);
        if (win_q.size() > WIN) void'(win_q.pop_front());
        if (win_q.size() == WIN) begin
            s = win_q;
            s.sort();
            e.med = s[WIN/2];
            e.mn  = s[0];
            e.mx  = s[WIN-1];
            exp_q.push_back(e);
            last_med = e.med;
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %0d, no output expected", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("median", 32'(out_data), e.med);
`ifdef MEDIAN_FILTER_MINMAX_EN
                check("min", 32'(out_min), e.mn);
                check("max", 32'(out_max), e.mx);
`endif
            end
        end
    end

    // called at posedge+1, returns at posedge+1 after the accepting edge
    task automatic send(input logic [WIDTH-1:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end else begin
            model_push(int'(v));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_clear(input logic with_valid);
        drain();
        clear    = 1'b1;
        in_valid = with_valid;
        in_data  = WIDTH'($urandom);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        win_q.delete();
        check("clear_fill_cnt", 32'(fill_cnt), 0);
        check("clear_out_valid", 32'(out_valid), 0);
        check("clear_out_data_hold", 32'(out_data), last_med);
    endtask

    task automatic send3(input logic [3:0] v, input logic ev, input int ed);
        in3_valid = 1'b1;
        in3_data  = v;
        @(posedge clk); #1;
        in3_valid = 1'b0;
        check("w3_valid", 32'(out3_valid), 32'(ev));
        if (ev) check("w3_median", 32'(out3_data), ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] od;
        logic [CW-1:0] fc;
        logic [WIDTH-1:0] v;
        int vals1[8] = '{10, 50, 20, 40, 30, 0, 60, 5};
        int dups[6] = '{255, 255, 0, 0, 255, 0};

        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_fill_cnt", 32'(fill_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);
`ifdef MEDIAN_FILTER_MINMAX_EN
        check("rst_out_min", 32'(out_min), 0);
        check("rst_out_max", 32'(out_max), 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        send3(4'd3, 1'b0, 0);
        send3(4'd9, 1'b0, 0);
        send3(4'd1, 1'b1, 3);
        send3(4'd7, 1'b1, 7);
        send3(4'd15, 1'b1, 7);

        // first window: latency and value on the WIN-th accept
        for (int i = 0; i < 8; i++) begin
            send(WIDTH'(vals1[i]));
            if (i == 3) begin
                check("fill4_cnt", 32'(fill_cnt), 4);
                check("fill4_out_valid", 32'(out_valid), 0);
            end
            if (i == 4) begin
                check("first_out_valid", 32'(out_valid), 1);
                check("first_out_data", 32'(out_data), 30);
`ifdef MEDIAN_FILTER_MINMAX_EN
                check("first_out_min", 32'(out_min), 10);
                check("first_out_max", 32'(out_max), 50);
`endif
            end
        end

        // clear mid-fill drops the sample; a full new window is needed
        do_clear(1'b0);
        for (int i = 0; i < 3; i++) send(WIDTH'($urandom));
        do_clear(1'b1);
        for (int i = 0; i < 4; i++) send(WIDTH'($urandom));
        check("refill_cnt", 32'(fill_cnt), 4);
        check("refill_out_valid", 32'(out_valid), 0);
        send(WIDTH'($urandom));
        check("refill_first_valid", 32'(out_valid), 1);

        do_clear(1'b0);
        for (int i = 0; i < 6; i++) send(WIDTH'(dups[i]));

        // backpressure: output held, nothing accepted
        ready_force = 1'b0;
        @(posedge clk); #1;
        check("bp_out_valid", 32'(out_valid), 1);
        od = out_data;
        fc = fill_cnt;
        v  = WIDTH'($urandom);
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_data", 32'(out_data), 32'(od));
            check("bp_fill_cnt", 32'(fill_cnt), 32'(fc));
        end
        @(posedge clk); #1;
        ready_force = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 1);
        model_push(int'(v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_release_valid", 32'(out_valid), 1);
        drain();

        // random traffic with duplicates, extremes and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int mode;
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                @(posedge clk); #1;
            end else if (mode == 1 && $urandom_range(0, 9) == 0) begin
                do_clear(1'($urandom_range(0, 1)));
                rand_ready = 1'b1;
            end else if (mode < 5) begin
                send(WIDTH'($urandom_range(0, 3)));
            end else if (mode < 7) begin
                send($urandom_range(0, 1) != 0 ? '1 : '0);
            end else begin
                send(WIDTH'($urandom));
            end
        end
        drain();

        // asynchronous reset mid-RUN
        for (int i = 0; i < 6; i++) send(WIDTH'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_data", 32'(out_data), 0);
        check("arst_fill_cnt", 32'(fill_cnt), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        win_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send(WIDTH'($urandom));
        check("post_rst_valid", 32'(out_valid), 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
